arb3_sched: RTL



---
 rtl/arb3_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/arb3_sched.sv
// Three-way request arbiter (a, b, c) for one shared resource. Fixed-priority or
// round-robin selection, with a bounded hold time under contention and registered outputs.
module arb3_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       rr_en,
  output logic [2:0] gnt,
  output logic [1:0] gnt_code,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Handshake: requests are levels sampled at each rising edge. A requester holds its
  // request until gnt shows it as owner and drops it to release. gnt/gnt_code/busy/preempt
  // all change only on clock edges (or immediately on reset).

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       code_q, code_d;
  logic             busy_q, busy_d;
  logic             preempt_q, preempt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       mask_q, mask_d;

  logic [2:0] req;
  logic [2:0] cand;
  logic [2:0] win;
  logic       owner_req;
  logic       other_req;

  // Picks one requester from r. Round-robin starts the search just after the last owner;
  // when the last owner was C the round-robin order coincides with fixed priority.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic rr,
                                      input logic [2:0] last);
    logic [2:0] w;
    w = 3'b000;
    if (!rr || last == 3'b001) begin
      if (r[2])      w = 3'b100;
      else if (r[1]) w = 3'b010;
      else if (r[0]) w = 3'b001;
    end else if (last == 3'b100) begin
      if (r[1])      w = 3'b010;
      else if (r[0]) w = 3'b001;
      else if (r[2]) w = 3'b100;
    end else begin
      if (r[0])      w = 3'b001;
      else if (r[2]) w = 3'b100;
      else if (r[1]) w = 3'b010;
    end
    return w;
  endfunction

  function automatic logic [1:0] encode(input logic [2:0] g);
    logic [1:0] e;
    unique case (g)
      3'b100:  e = 2'b11;
      3'b010:  e = 2'b10;
      3'b001:  e = 2'b01;
      default: e = 2'b00;
    endcase
    return e;
  endfunction

  assign req       = {a, b, c};
  assign cand      = req & ~mask_q;
  assign win       = pick(cand, rr_en, last_q);
  assign owner_req = |(req & gnt_q);
  assign other_req = |(req & ~gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    mask_d    = mask_q;
    preempt_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The mask only ever shields one arbitration after a forced release.
        mask_d = 3'b000;
        if (|cand) begin
          state_d = S_GRANT;
          gnt_d   = win;
          cnt_d   = CNT_ONE;
        end
      end
      S_GRANT: begin
        if (!owner_req) begin
          state_d = S_IDLE;
          gnt_d   = 3'b000;
          cnt_d   = '0;
          last_d  = gnt_q;
        end else if (cnt_q == HOLD_MAX && other_req) begin
          state_d   = S_IDLE;
          gnt_d     = 3'b000;
          cnt_d     = '0;
          last_d    = gnt_q;
          mask_d    = gnt_q;
          preempt_d = 1'b1;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        cnt_d   = '0;
      end
    endcase
    code_d = encode(gnt_d);
    busy_d = (state_d == S_GRANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_q     <= 3'b000;
      code_q    <= 2'b00;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 3'b001;
      mask_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      mask_q    <= mask_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_code = code_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_code_match:  assert property (@(posedge clk) disable iff (!rst_n) code_q == encode(gnt_q));
  a_busy_match:  assert property (@(posedge clk) disable iff (!rst_n) busy_q == (|gnt_q));
  a_pre_pulse:   assert property (@(posedge clk) disable iff (!rst_n)
                                  preempt_q |-> (gnt_q == 3'b000) ##1 !preempt_q);

endmodule
